// File: rtl/instr_decode_pkg.sv
// ---------------------------------------------------------------------------
// instr_decode_pkg
// Shared instruction-map definitions for the hamming/parity processor.
//   - k* opcode constants and the op_mne mnemonic enum
//   - dec_t: the already-decoded instruction bundle carried to execute
//   - decodeWord(): field split + opcode classification of a raw 9-bit word
// ---------------------------------------------------------------------------
package instr_decode_pkg;

  localparam logic [3:0] kADD     = 4'd0;
  localparam logic [3:0] kSUB     = 4'd1;
  localparam logic [3:0] kBXOR    = 4'd2;
  localparam logic [3:0] kRXOR    = 4'd3;
  localparam logic [3:0] kAND     = 4'd4;
  localparam logic [3:0] kSHIFT   = 4'd5;
  localparam logic [3:0] kNOT     = 4'd6;
  localparam logic [3:0] kMOV     = 4'd7;
  localparam logic [3:0] kPASS    = 4'd8;
  localparam logic [3:0] kOPC_MAX = 4'd8;

  typedef enum logic [3:0] {
    ADD   = kADD,
    SUB   = kSUB,
    BXOR  = kBXOR,
    RXOR  = kRXOR,
    AND   = kAND,
    SHIFT = kSHIFT,
    NOT   = kNOT,
    MOV   = kMOV,
    PASS  = kPASS
  } op_mne;

  typedef struct packed {
    op_mne       op;
    logic [2:0]  rd;
    logic [1:0]  fld;
    logic        illegal;
  } dec_t;

  // Opcodes above kOPC_MAX are not in the map: they travel on as PASS so
  // execute does nothing with them, and the illegal flag records why.
  function automatic dec_t decodeWord(input logic [8:0] instr);
    dec_t       d;
    logic [3:0] opc;
    opc       = instr[8:5];
    d.rd      = instr[4:2];
    d.fld     = instr[1:0];
    d.illegal = (opc > kOPC_MAX);
    d.op      = d.illegal ? PASS : op_mne'(opc);
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_skid_buf.sv
// ---------------------------------------------------------------------------
// skid_buf
// Two-entry skid buffer with a registered in_ready, so backpressure from the
// consumer never reaches the producer combinationally. Strict FIFO order.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready producer handshake (in_ready is a flop)
//   in_data           payload of type T
//   out_valid/out_ready consumer handshake
//   out_data          payload of type T, held stable while stalled
// ---------------------------------------------------------------------------
module skid_buf
  import instr_decode_pkg::*;
#(
  parameter type T = dec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_in_ready;
  T           r_main;
  T           r_skid;
  logic       w_acc;
  logic       w_iss;

  assign w_acc     = in_valid & r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign w_iss     = out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_data  = r_main;

  // Occupancy transitions. TWO cannot accept because in_ready is low there.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: if (w_acc) w_next = S_ONE;
      S_ONE: begin
        if (w_acc && !w_iss)      w_next = S_TWO;
        else if (!w_acc && w_iss) w_next = S_EMPTY;
      end
      S_TWO:   if (w_iss) w_next = S_ONE;
      default: w_next = S_EMPTY;
    endcase
  end

  // in_ready is precomputed from the next state so it comes straight off a
  // flop. The main register only changes on issue or when it is empty,
  // which keeps out_data stable during a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_TWO);
      case (r_state)
        S_EMPTY: if (w_acc) r_main <= in_data;
        S_ONE: begin
          if (w_acc && w_iss)  r_main <= in_data;
          if (w_acc && !w_iss) r_skid <= in_data;
        end
        S_TWO:   if (w_iss) r_main <= r_skid;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Decode stage: splits raw 9-bit words from fetch into opcode/rd/fld,
// classifies the opcode, and hands a registered decoded bundle to execute
// through a skid buffer. Tracks issued-instruction count and a sticky error
// flag for illegal opcodes.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      fetch handshake; in_instr is the raw word
//   out_valid/out_ready    execute handshake
//   out_op/out_rd/out_fld  decoded fields; out_illegal marks opcodes 9-15
//   err_sticky/err_clr     sticky illegal-issue flag and its clear
//   issue_cnt              wrapping count of completed output handshakes
// ---------------------------------------------------------------------------
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int IW    = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [2:0]       out_rd,
  output logic [1:0]       out_fld,
  output logic             out_illegal,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] issue_cnt
);

  if (IW != 9) begin : g_bad_iw
    $error("instr_decode: IW must be 9 for this ISA");
  end

  dec_t             w_dec;
  dec_t             w_out;
  logic             w_iss;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_issue_cnt;

  // Decode happens before buffering, so the stored bundle is already decoded.
  assign w_dec = decodeWord(in_instr[8:0]);

  skid_buf #(
    .T (dec_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out)
  );

  assign w_iss       = out_valid & out_ready;
  assign out_op      = w_out.op;
  assign out_rd      = w_out.rd;
  assign out_fld     = w_out.fld;
  assign out_illegal = w_out.illegal;
  assign err_sticky  = r_err_sticky;
  assign issue_cnt   = r_issue_cnt;

  // Setting has priority over err_clr so an illegal issue is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (w_iss && w_out.illegal) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  // Free-running wrap on overflow; no saturation or flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
    end else if (w_iss) begin
      r_issue_cnt <= r_issue_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// ---------------------------------------------------------------------------
// tb_instr_decode
// Self-checking bench for instr_decode: directed vector table, error-flag
// sequences, backpressure and reset-in-flight sequences, counter wrap, and
// a randomized stream checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instr_decode;
  import instr_decode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_op;
  logic [2:0] out_rd;
  logic [1:0] out_fld;
  logic       out_illegal;
  logic       err_sticky;
  logic       err_clr;
  logic [7:0] issue_cnt;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [8:0] instr;
    logic [3:0] op;
    logic [2:0] rd;
    logic [1:0] fld;
    logic       illegal;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  instr_decode #(
    .IW    (9),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_fld     (out_fld),
    .out_illegal (out_illegal),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr),
    .issue_cnt   (issue_cnt)
  );

  // Reference decode straight from the instruction map using plain arithmetic.
  function automatic logic [9:0] modelDecode(input int w);
    int opc, rd, fld;
    logic ill;
    logic [3:0] op;
    opc = w / 32;
    rd  = (w / 4) % 8;
    fld = w % 4;
    ill = (opc > 8);
    op  = ill ? 4'd8 : 4'(opc);
    return {op, 3'(rd), 2'(fld), ill};
  endfunction

  function automatic logic [9:0] outBits();
    return {out_op, out_rd, out_fld, out_illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] w, input logic r);
    in_valid  = v;
    in_instr  = w;
    out_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    err_clr = 1'b0;
    applyStimulus(1'b0, 9'h000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8:0] words[3];
    logic [8:0] cur;
    logic [9:0] q[$];
    logic [9:0] expBits;
    int idx, cyc, occ, issued, expCnt;
    logic acc, iss, rdy;

    // opcode = bits 8:5, rd = bits 4:2, fld = bits 1:0
    vecs[0] = '{9'h000, 4'd0, 3'd0, 2'd0, 1'b0};  // ADD
    vecs[1] = '{9'h0A5, 4'd5, 3'd1, 2'd1, 1'b0};  // SHIFT rd1 fld1
    vecs[2] = '{9'h10F, 4'd8, 3'd3, 2'd3, 1'b0};  // PASS rd3 fld3
    vecs[3] = '{9'h020, 4'd1, 3'd0, 2'd0, 1'b0};  // SUB
    vecs[4] = '{9'h04B, 4'd2, 3'd2, 2'd3, 1'b0};  // BXOR
    vecs[5] = '{9'h064, 4'd3, 3'd1, 2'd0, 1'b0};  // RXOR
    vecs[6] = '{9'h088, 4'd4, 3'd2, 2'd0, 1'b0};  // AND
    vecs[7] = '{9'h0C6, 4'd6, 3'd1, 2'd2, 1'b0};  // NOT
    vecs[8] = '{9'h0FF, 4'd7, 3'd7, 2'd3, 1'b0};  // MOV
    vecs[9] = '{9'h13F, 4'd8, 3'd7, 2'd3, 1'b1};  // opcode 9 -> illegal

    // Reset state
    doReset();
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_bits", outBits(), 0);
    checkOutput("rst_err", err_sticky, 0);
    checkOutput("rst_cnt", issue_cnt, 0);

    // Streaming table with out_ready=1: one output per cycle, 1-cycle latency
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 1'b1);
      tick();
      checkOutput("tbl_valid", out_valid, 1);
      checkOutput("tbl_op", out_op, vecs[i].op);
      checkOutput("tbl_rd", out_rd, vecs[i].rd);
      checkOutput("tbl_fld", out_fld, vecs[i].fld);
      checkOutput("tbl_illegal", out_illegal, vecs[i].illegal);
    end
    applyStimulus(1'b0, 9'h000, 1'b1);
    tick();
    checkOutput("tbl_drained", out_valid, 0);
    checkOutput("tbl_cnt", issue_cnt, 10);
    checkOutput("tbl_err", err_sticky, 1);

    // err_clr clears; simultaneous illegal issue and clear keeps it set
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_cleared", err_sticky, 0);
    applyStimulus(1'b1, 9'h1E0, 1'b1);
    tick();
    checkOutput("ill_op", out_op, 8);
    checkOutput("ill_flag", out_illegal, 1);
    checkOutput("ill_err_before_issue", err_sticky, 0);
    applyStimulus(1'b0, 9'h000, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_set_wins", err_sticky, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    applyStimulus(1'b1, 9'h020, 1'b1);
    tick();
    applyStimulus(1'b0, 9'h000, 1'b1);
    tick();
    checkOutput("err_legal_no_set", err_sticky, 0);
    checkOutput("err_cnt", issue_cnt, 12);

    // Backpressure: three words with out_ready=0
    words[0] = 9'h0A5;
    words[1] = 9'h10F;
    words[2] = 9'h1E0;
    applyStimulus(1'b1, words[0], 1'b0);
    tick();
    checkOutput("bp_ready1", in_ready, 1);
    checkOutput("bp_out1", outBits(), modelDecode(int'(words[0])));
    applyStimulus(1'b1, words[1], 1'b0);
    tick();
    checkOutput("bp_ready2", in_ready, 0);
    checkOutput("bp_out2", outBits(), modelDecode(int'(words[0])));
    applyStimulus(1'b1, words[2], 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("bp_hold_ready", in_ready, 0);
      checkOutput("bp_hold_out", outBits(), modelDecode(int'(words[0])));
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_rel1", outBits(), modelDecode(int'(words[1])));
    tick();
    checkOutput("bp_rel2", outBits(), modelDecode(int'(words[2])));
    applyStimulus(1'b0, 9'h000, 1'b1);
    tick();
    checkOutput("bp_empty", out_valid, 0);
    checkOutput("bp_cnt", issue_cnt, 15);

    // Reset while holding two words
    applyStimulus(1'b1, 9'h0FF, 1'b0);
    tick();
    applyStimulus(1'b1, 9'h0C6, 1'b0);
    tick();
    checkOutput("rst2_full", in_ready, 0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 9'h000, 1'b1);
    tick();
    rst_n = 1'b1;
    checkOutput("rst2_valid", out_valid, 0);
    checkOutput("rst2_ready", in_ready, 1);
    checkOutput("rst2_cnt", issue_cnt, 0);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("rst2_no_issue_valid", out_valid, 0);
    checkOutput("rst2_no_issue_cnt", issue_cnt, 0);

    // 257 issues wrap an 8-bit counter to 1
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, 9'(i), 1'b1);
      tick();
    end
    applyStimulus(1'b0, 9'h000, 1'b1);
    tick();
    checkOutput("wrap_cnt", issue_cnt, 1);

    // Randomized stream against queue/occupancy model
    doReset();
    idx = 0; cyc = 0; occ = 0; issued = 0; expCnt = 0;
    cur = 9'($urandom_range(0, 511));
    while ((idx < 1000 || q.size() > 0) && cyc < 20000) begin
      rdy = 1'($urandom_range(0, 1));
      applyStimulus(idx < 1000, (idx < 1000) ? cur : 9'h000, rdy);
      checkOutput("rand_flow", {30'd0, in_ready, out_valid}, {30'd0, occ < 2, occ > 0});
      acc = in_valid && in_ready;
      iss = out_valid && out_ready;
      if (iss) begin
        if (q.size() == 0) begin
          checkOutput("rand_spurious", 1, 0);
        end else begin
          expBits = q.pop_front();
          checkOutput("rand_order", outBits(), expBits);
        end
        issued++;
        expCnt++;
      end
      if (acc) begin
        q.push_back(modelDecode(int'(cur)));
        idx++;
        cur = 9'($urandom_range(0, 511));
      end
      occ = occ + int'(acc) - int'(iss);
      tick();
      cyc++;
    end
    if (cyc >= 20000) checkOutput("rand_timeout", cyc, 0);
    checkOutput("rand_issued", issued, 1000);
    checkOutput("rand_cnt", issue_cnt, expCnt % 256);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
